// File: rtl/sv32_ptw_pkg.sv
// Shared types and constants for the Sv32 page-table walker.
package sv32_ptw_pkg;

    localparam int unsigned PA_W          = 34;
    localparam int unsigned REFILL_W      = 52;
    localparam int unsigned VPN_W         = 20;
    localparam int unsigned VPN_PART_W    = 10;
    localparam int unsigned PPN_W         = 22;
    localparam int unsigned PTE_W         = 32;
    localparam int unsigned FLAGS_W       = 8;
    localparam int unsigned PTE_SIZE_LG2  = 2;
    localparam int unsigned PAGE_OFFSET_W = 12;
    localparam int unsigned LEVELS        = 2;

    typedef struct packed {
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    typedef struct packed {
        logic               fault;
        logic               superpage;
        logic [VPN_W-1:0]   vpn;
        logic [PPN_W-1:0]   ppn;
        logic [FLAGS_W-1:0] flags;
    } refill_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_REQ,
        ST_L1_WAIT,
        ST_L0_REQ,
        ST_L0_WAIT,
        ST_PUSH
    } ptw_state_e;

    // Byte address of PTE 'idx' inside the page-table page 'base'.
    function automatic logic [PA_W-1:0] pte_addr(input logic [PPN_W-1:0]      base,
                                                 input logic [VPN_PART_W-1:0] idx);
        return (PA_W'(base) << PAGE_OFFSET_W) + (PA_W'(idx) << PTE_SIZE_LG2);
    endfunction

    function automatic refill_t fault_entry(input logic [VPN_W-1:0] vpn);
        refill_t e;
        e       = '0;
        e.fault = 1'b1;
        e.vpn   = vpn;
        return e;
    endfunction

endpackage

// File: rtl/sv32_ptw_if.sv
// Miss request, PTE memory port and refill-FIFO push bundle of the walker.
interface sv32_ptw_if;
    import sv32_ptw_pkg::*;

    logic             miss_valid;
    logic             miss_ready;
    logic [VPN_W-1:0] miss_vpn;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [PA_W-1:0]  mem_req_addr;
    logic             mem_rsp_valid;
    logic [PTE_W-1:0] mem_rsp_data;
    logic             push;
    refill_t          push_data;
    logic             fifo_full;

    modport master (
        input  miss_valid, miss_vpn, mem_req_ready, mem_rsp_valid, mem_rsp_data, fifo_full,
        output miss_ready, mem_req_valid, mem_req_addr, push, push_data
    );

    modport slave (
        output miss_valid, miss_vpn, mem_req_ready, mem_rsp_valid, mem_rsp_data, fifo_full,
        input  miss_ready, mem_req_valid, mem_req_addr, push, push_data
    );

endinterface

// File: rtl/sv32_ptw_pte_check.sv
// Combinational PTE decode: invalid encoding, leaf, and misaligned superpage (level 1 only).
module sv32_pte_check
    import sv32_ptw_pkg::*;
(
    input  pte_t pte_i,
    input  logic level_i,
    output logic invalid_o,
    output logic leaf_o,
    output logic misaligned_o
);

    assign invalid_o    = !pte_i.v || (pte_i.w && !pte_i.r);
    assign leaf_o       = pte_i.r || pte_i.x;
    assign misaligned_o = level_i && leaf_o && (pte_i.ppn[VPN_PART_W-1:0] != '0);

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 two-level page-table walker: one miss in, one refill/fault entry pushed out.
module sv32_ptw
    import sv32_ptw_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PPN_W-1:0] i_satp_ppn,
    output logic             busy,
    sv32_ptw_if.master       bus
);

    ptw_state_e       state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PPN_W-1:0] satp_q, satp_d;
    logic [PPN_W-1:0] l0_ppn_q, l0_ppn_d;
    refill_t          entry_q, entry_d;

    pte_t rsp_pte;
    logic pte_invalid;
    logic pte_leaf;
    logic pte_misaligned;

    assign rsp_pte = pte_t'(bus.mem_rsp_data);

    sv32_pte_check u_pte_check (
        .pte_i        (rsp_pte),
        .level_i      (state_q == ST_L1_WAIT),
        .invalid_o    (pte_invalid),
        .leaf_o       (pte_leaf),
        .misaligned_o (pte_misaligned)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            vpn_q    <= '0;
            satp_q   <= '0;
            l0_ppn_q <= '0;
            entry_q  <= '0;
        end else begin
            state_q  <= state_d;
            vpn_q    <= vpn_d;
            satp_q   <= satp_d;
            l0_ppn_q <= l0_ppn_d;
            entry_q  <= entry_d;
        end
    end

    // Walk sequencing; responses are only consumed in the two WAIT states.
    always_comb begin
        state_d           = state_q;
        vpn_d             = vpn_q;
        satp_d            = satp_q;
        l0_ppn_d          = l0_ppn_q;
        entry_d           = entry_q;
        bus.miss_ready    = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.push          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    vpn_d   = bus.miss_vpn;
                    satp_d  = i_satp_ppn;
                    state_d = ST_L1_REQ;
                end
            end
            ST_L1_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = pte_addr(satp_q, vpn_q[VPN_W-1:VPN_PART_W]);
                if (bus.mem_req_ready) state_d = ST_L1_WAIT;
            end
            ST_L1_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    if (pte_invalid || pte_misaligned) begin
                        entry_d = fault_entry(vpn_q);
                        state_d = ST_PUSH;
                    end else if (pte_leaf) begin
                        entry_d.fault     = 1'b0;
                        entry_d.superpage = 1'b1;
                        entry_d.vpn       = vpn_q;
                        entry_d.ppn       = rsp_pte.ppn;
                        entry_d.flags     = bus.mem_rsp_data[FLAGS_W-1:0];
                        state_d           = ST_PUSH;
                    end else begin
                        l0_ppn_d = rsp_pte.ppn;
                        state_d  = ST_L0_REQ;
                    end
                end
            end
            ST_L0_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = pte_addr(l0_ppn_q, vpn_q[VPN_PART_W-1:0]);
                if (bus.mem_req_ready) state_d = ST_L0_WAIT;
            end
            ST_L0_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    // A pointer at the last level has nowhere to go, so it faults.
                    if (pte_invalid || !pte_leaf) begin
                        entry_d = fault_entry(vpn_q);
                    end else begin
                        entry_d.fault     = 1'b0;
                        entry_d.superpage = 1'b0;
                        entry_d.vpn       = vpn_q;
                        entry_d.ppn       = rsp_pte.ppn;
                        entry_d.flags     = bus.mem_rsp_data[FLAGS_W-1:0];
                    end
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                bus.push = !bus.fifo_full;
                if (!bus.fifo_full) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign bus.push_data = entry_q;

endmodule
